// File: rtl/bs_batch_dispatcher.sv
// rtl/bs_batch_dispatcher.sv - multi-core Black-Scholes job dispatcher with in-order reorder buffer
module bs_batch_dispatcher #(
    parameter int NUM_CORES = 4,
    parameter int WIDTH     = 16,
    parameter int FRAC      = 10,
    parameter int TAG_W     = 8,
    parameter int DEPTH     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_S,
    input  logic [WIDTH-1:0]             in_K,
    input  logic [WIDTH-1:0]             in_r,
    input  logic [WIDTH-1:0]             in_sigma,
    input  logic [WIDTH-1:0]             in_T,
    input  logic [TAG_W-1:0]             in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_price,
    output logic [TAG_W-1:0]             out_tag,
    output logic                         out_err,
    output logic [NUM_CORES-1:0]         core_start,
    output logic [NUM_CORES*5*WIDTH-1:0] core_ops,
    input  logic [NUM_CORES-1:0]         core_done,
    input  logic [NUM_CORES*WIDTH-1:0]   core_price,
    output logic [$clog2(DEPTH):0]       outstanding
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OPS_W = 5 * WIDTH;
    // A misconfigured instance never accepts work rather than mis-pricing it.
    localparam logic CFG_OK = (FRAC >= 0) && (FRAC < WIDTH) && (DEPTH >= NUM_CORES);
    localparam logic signed [WIDTH-1:0] ZERO = '0;

    logic [PTR_W-1:0]             r_wr_ptr;
    logic [PTR_W-1:0]             r_rd_ptr;
    logic [CNT_W-1:0]             r_outstanding;
    logic [NUM_CORES-1:0]         r_busy;
    logic [NUM_CORES-1:0]         r_done_q;
    logic [NUM_CORES-1:0]         r_core_start;
    logic [NUM_CORES*OPS_W-1:0]   r_core_ops;
    logic [PTR_W-1:0]             r_core_seq [NUM_CORES];
    logic [DEPTH-1:0]             r_rob_valid;
    logic [DEPTH-1:0]             r_rob_err;
    logic [WIDTH-1:0]             r_rob_price [DEPTH];
    logic [TAG_W-1:0]             r_rob_tag [DEPTH];

    logic [NUM_CORES-1:0]         w_capture;
    logic [NUM_CORES-1:0]         w_grant;
    logic                         w_any_idle;
    logic                         w_job_ok;
    logic                         w_accept;
    logic                         w_pop;
    logic [PTR_W-1:0]             w_wr_ptr_nxt;
    logic [PTR_W-1:0]             w_rd_ptr_nxt;

    assign w_any_idle = ~&r_busy;
    // Lowest-index idle core: isolate the lowest zero bit of the busy vector.
    assign w_grant    = ~r_busy & (r_busy + NUM_CORES'(1));
    assign w_capture  = core_done & ~r_done_q & r_busy;
    assign w_job_ok   = ($signed(in_S) > ZERO) && ($signed(in_K) > ZERO) &&
                        ($signed(in_sigma) > ZERO) && ($signed(in_T) > ZERO);

    assign in_ready   = rst_n & CFG_OK & (r_outstanding < CNT_W'(DEPTH)) & w_any_idle;
    assign w_accept   = in_valid & in_ready;
    assign out_valid  = r_rob_valid[r_rd_ptr];
    assign out_price  = r_rob_price[r_rd_ptr];
    assign out_tag    = r_rob_tag[r_rd_ptr];
    assign out_err    = r_rob_err[r_rd_ptr];
    assign w_pop      = out_valid & out_ready;

    assign w_wr_ptr_nxt = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

    assign core_start  = r_core_start;
    assign core_ops    = r_core_ops;
    assign outstanding = r_outstanding;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_outstanding <= '0;
            r_busy        <= '0;
            r_done_q      <= '0;
            r_core_start  <= '0;
            r_core_ops    <= '0;
            r_rob_valid   <= '0;
            r_rob_err     <= '0;
            for (int c = 0; c < NUM_CORES; c++) begin
                r_core_seq[c] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                r_rob_price[i] <= '0;
                r_rob_tag[i]   <= '0;
            end
        end else begin
            r_done_q     <= core_done;
            r_core_start <= '0;

            for (int c = 0; c < NUM_CORES; c++) begin
                if (w_capture[c]) begin
                    r_busy[c]                    <= 1'b0;
                    r_rob_valid[r_core_seq[c]]   <= 1'b1;
                    r_rob_err[r_core_seq[c]]     <= 1'b0;
                    r_rob_price[r_core_seq[c]]   <= core_price[c*WIDTH +: WIDTH];
                end
            end

            if (w_accept) begin
                r_rob_tag[r_wr_ptr] <= in_tag;
                r_wr_ptr            <= w_wr_ptr_nxt;
                if (w_job_ok) begin
                    for (int c = 0; c < NUM_CORES; c++) begin
                        if (w_grant[c]) begin
                            r_busy[c]                      <= 1'b1;
                            r_core_start[c]                <= 1'b1;
                            r_core_seq[c]                  <= r_wr_ptr;
                            r_core_ops[c*OPS_W +: OPS_W]   <= {in_S, in_K, in_r, in_sigma, in_T};
                        end
                    end
                end else begin
                    // Rejected jobs bypass the cores and complete immediately.
                    r_rob_valid[r_wr_ptr] <= 1'b1;
                    r_rob_err[r_wr_ptr]   <= 1'b1;
                    r_rob_price[r_wr_ptr] <= '0;
                end
            end

            if (w_pop) begin
                r_rob_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr              <= w_rd_ptr_nxt;
            end

            case ({w_accept, w_pop})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_bs_batch_dispatcher.sv
// tb/tb_bs_batch_dispatcher.sv - scoreboard bench for bs_batch_dispatcher with stub pricing cores
module tb_bs_batch_dispatcher;

    localparam int NC = 4;
    localparam int W  = 16;
    localparam int TW = 8;
    localparam int D  = 8;

    typedef struct packed {
        logic [W-1:0]  price;
        logic [TW-1:0] tag;
        logic          err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_S = '0;
    logic [W-1:0]     in_K = '0;
    logic [W-1:0]     in_r = '0;
    logic [W-1:0]     in_sigma = '0;
    logic [W-1:0]     in_T = '0;
    logic [TW-1:0]    in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     out_price;
    logic [TW-1:0]    out_tag;
    logic             out_err;
    logic [NC-1:0]    core_start;
    logic [NC*5*W-1:0] core_ops;
    logic [NC-1:0]    core_done = '0;
    logic [NC*W-1:0]  core_price = '0;
    logic [$clog2(D):0] outstanding;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   core_lat [NC] = '{20, 20, 20, 20};
    int   rem [NC] = '{0, 0, 0, 0};
    logic [W-1:0] pend [NC];
    int   start_cnt [NC] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    bs_batch_dispatcher #(
        .NUM_CORES(NC), .WIDTH(W), .FRAC(10), .TAG_W(TW), .DEPTH(D)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_S(in_S), .in_K(in_K), .in_r(in_r), .in_sigma(in_sigma), .in_T(in_T), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_price(out_price), .out_tag(out_tag), .out_err(out_err),
        .core_start(core_start), .core_ops(core_ops),
        .core_done(core_done), .core_price(core_price),
        .outstanding(outstanding)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stub core: price = S - K + 0x0A00, done pulses high for one cycle after core_lat cycles.
    always @(negedge clk) begin
        for (int c = 0; c < NC; c++) begin
            if (core_done[c]) core_done[c] = 1'b0;
            if (core_start[c]) begin
                start_cnt[c] = start_cnt[c] + 1;
                rem[c]  = core_lat[c];
                pend[c] = core_ops[c*5*W + 4*W +: W] - core_ops[c*5*W + 3*W +: W] + 16'h0A00;
            end else if (rem[c] > 0) begin
                rem[c] = rem[c] - 1;
                if (rem[c] == 0) begin
                    core_done[c] = 1'b1;
                    core_price[c*W +: W] = pend[c];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output tag=%0h price=%0h expected=none", out_tag, out_price);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_tag", out_tag, mon_e.tag);
                chk("out_price", out_price, mon_e.price);
                chk("out_err", out_err, mon_e.err);
            end
        end
    end

    task automatic send(input logic [W-1:0] s, input logic [W-1:0] k, input logic [W-1:0] r,
                        input logic [W-1:0] sg, input logic [W-1:0] t, input logic [TW-1:0] tag,
                        input logic [W-1:0] ep, input logic ee);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        in_S = s; in_K = k; in_r = r; in_sigma = sg; in_T = t; in_tag = tag;
        in_valid = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.price = ep; e.tag = tag; e.err = ee;
                exp_q.push_back(e);
                ok = 1'b1;
                tick();
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout tag=%0h actual=not_accepted expected=accepted", tag);
        end
    endtask

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("drain_pending", exp_q.size(), 0);
        chk("drain_outstanding", outstanding, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int  base [NC];
        int  tot;
        bit  seen;
        bit  bad;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_price", out_price, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_ops", core_ops, 0);
        chk("rst_outstanding", outstanding, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", in_ready, 1);
        tick();

        // Single job, start pulse and operand registration
        send(16'h6400, 16'h6400, 16'h0033, 16'h00CC, 16'h0400, 8'h01, 16'h0A00, 1'b0);
        @(negedge clk);
        chk("t1_core_start", core_start, 4'b0001);
        chk("t1_core_ops", core_ops[79:0], 80'h6400_6400_0033_00CC_0400);
        @(negedge clk);
        chk("t1_start_one_cycle", core_start, 4'b0000);
        tick();
        drain(100);

        // Out-of-order completion, in-order return
        core_lat = '{40, 10, 30, 5};
        for (int c = 0; c < NC; c++) base[c] = start_cnt[c];
        send(16'h0500, 16'h0400, 16'h0033, 16'h00CC, 16'h0400, 8'h01, 16'h0B00, 1'b0);
        send(16'h0600, 16'h0400, 16'h0033, 16'h00CC, 16'h0400, 8'h02, 16'h0C00, 1'b0);
        send(16'h0700, 16'h0400, 16'h0033, 16'h00CC, 16'h0400, 8'h03, 16'h0D00, 1'b0);
        send(16'h0800, 16'h0400, 16'h0033, 16'h00CC, 16'h0400, 8'h04, 16'h0E00, 1'b0);
        drain(200);
        for (int c = 0; c < NC; c++) chk("t2_starts_per_core", start_cnt[c] - base[c], 1);

        // Rejected jobs interleaved with valid ones
        core_lat = '{5, 5, 5, 5};
        tot = start_cnt[0] + start_cnt[1] + start_cnt[2] + start_cnt[3];
        send(16'h0600, 16'h0400, 16'h0033, 16'h00CC, 16'h0400, 8'h05, 16'h0C00, 1'b0);
        send(16'h0600, 16'h0400, 16'h0033, 16'h0000, 16'h0400, 8'h07, 16'h0000, 1'b1);
        send(16'h0400, 16'h0500, 16'h0033, 16'h00CC, 16'h0400, 8'h09, 16'h0900, 1'b0);
        send(16'hFFFF, 16'h0400, 16'h0033, 16'h00CC, 16'h0400, 8'h0B, 16'h0000, 1'b1);
        send(16'h0400, 16'h0400, 16'h0033, 16'h00CC, 16'h0001, 8'h0C, 16'h0A00, 1'b0);
        drain(200);
        chk("t3_core_starts", start_cnt[0] + start_cnt[1] + start_cnt[2] + start_cnt[3] - tot, 3);

        // ROB full with a stalled consumer
        core_lat = '{3, 3, 3, 3};
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            send(16'h0400 + 16'(i), 16'h0400, 16'h0033, 16'h00CC, 16'h0400, 8'h10 + 8'(i),
                 16'h0A00 + 16'(i), 1'b0);
        repeat (12) tick();
        @(negedge clk);
        chk("t4_ready_full", in_ready, 0);
        chk("t4_outstanding_full", outstanding, 8);
        chk("t4_out_valid_full", out_valid, 1);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("t4_ready_after_pop", in_ready, 1);
        chk("t4_outstanding_after_pop", outstanding, 7);
        tick();
        out_ready = 1'b1;
        send(16'h0408, 16'h0400, 16'h0033, 16'h00CC, 16'h0400, 8'h18, 16'h0A08, 1'b0);
        send(16'h0409, 16'h0400, 16'h0033, 16'h00CC, 16'h0400, 8'h19, 16'h0A09, 1'b0);
        drain(200);

        // All cores busy gates in_ready until the first capture
        core_lat = '{100, 100, 100, 100};
        for (int i = 0; i < 4; i++)
            send(16'h0400 + 16'(i), 16'h0400, 16'h0033, 16'h00CC, 16'h0400, 8'h20 + 8'(i),
                 16'h0A00 + 16'(i), 1'b0);
        seen = 1'b0;
        bad  = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (core_done != '0) seen = 1'b1;
            else if (in_ready) bad = 1'b1;
        end
        chk("t5_ready_low_while_busy", bad, 0);
        chk("t5_done_seen", seen, 1);
        chk("t5_ready_before_capture", in_ready, 0);
        @(negedge clk);
        #1;
        chk("t5_ready_after_capture", in_ready, 1);
        tick();
        drain(400);

        // Reset with jobs in flight
        core_lat = '{30, 30, 30, 30};
        for (int i = 0; i < 3; i++)
            send(16'h0400 + 16'(i), 16'h0400, 16'h0033, 16'h00CC, 16'h0400, 8'h30 + 8'(i),
                 16'h0A00 + 16'(i), 1'b0);
        repeat (5) tick();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_outstanding", outstanding, 0);
        chk("t6_rst_in_ready", in_ready, 0);
        tick();
        rst_n = 1'b1;
        repeat (40) tick();
        @(negedge clk);
        chk("t6_stale_out_valid", out_valid, 0);
        chk("t6_stale_outstanding", outstanding, 0);
        tick();
        send(16'h0800, 16'h0400, 16'h0033, 16'h00CC, 16'h0400, 8'h2A, 16'h0E00, 1'b0);
        drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
